// File: rtl/serial_acc_pkg.sv
// serial_acc_pkg: shared state encoding, default width and adder helper for the accumulator slice
package serial_acc_pkg;
   localparam int ACC_N = 8;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } dp_state_e;
   function automatic logic maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/serial_acc_if.sv
// serial_acc_if: controller-to-datapath command and status bundle
interface serial_acc_if #(parameter int N = serial_acc_pkg::ACC_N);
   logic         clear_acc;
   logic         load_input;
   logic [N-1:0] data_in;
   logic         done;
   logic         busy;
   logic [N-1:0] acc_out;
   logic         overflow;
   modport master (output clear_acc, load_input, data_in, input done, busy, acc_out, overflow);
   modport slave  (input clear_acc, load_input, data_in, output done, busy, acc_out, overflow);
endinterface

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: single full adder with a registered carry for LSB-first serial addition
module bit_serial_adder
   import serial_acc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);
   logic carry_q, carry_d;
   assign s  = a ^ b ^ carry_q;
   assign co = maj(a, b, carry_q);
   always_comb carry_d = clr ? 1'b0 : en ? co : carry_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) carry_q <= 1'b0;
      else       carry_q <= carry_d;
endmodule

// File: rtl/serial_acc_datapath.sv
// serial_acc_datapath: bit-serial accumulator with committed result and sticky overflow
module serial_acc_datapath
   import serial_acc_pkg::*;
#(
   parameter int N = ACC_N
) (
   input logic         clk,
   input logic         reset,
   serial_acc_if.slave bus
);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   dp_state_e    state_q, state_d;
   logic [N-1:0] op_q, op_d, acc_sr_q, acc_sr_d, acc_out_q, acc_out_d, sum_vec;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic         ovf_q, ovf_d, load_acc, s, co;
   assign load_acc = (state_q == IDLE) & bus.load_input & ~bus.clear_acc;
   assign sum_vec  = N'({s, acc_sr_q} >> 1);
   bit_serial_adder u_add (
      .clk   (clk),
      .reset (reset),
      .clr   (load_acc | bus.clear_acc),
      .en    (state_q == SHIFT),
      .a     (acc_sr_q[0]),
      .b     (op_q[0]),
      .s     (s),
      .co    (co)
   );
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acc_sr_d  = acc_sr_q;
      cnt_d     = cnt_q;
      acc_out_d = acc_out_q;
      ovf_d     = ovf_q;
      if (bus.clear_acc) begin
         state_d   = IDLE;
         op_d      = '0;
         acc_sr_d  = '0;
         cnt_d     = '0;
         acc_out_d = '0;
         ovf_d     = 1'b0;
      end else if (state_q == IDLE) begin
         if (bus.load_input) begin
            op_d     = bus.data_in;
            acc_sr_d = acc_out_q;
            cnt_d    = '0;
            state_d  = SHIFT;
         end
      end else if (state_q == SHIFT) begin
         acc_sr_d = sum_vec;
         op_d     = op_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         // last bit: commit the finished sum and fold its carry-out into the sticky flag
         if (cnt_q == CNT_W'(N - 1)) begin
            acc_out_d = sum_vec;
            ovf_d     = ovf_q | co;
            state_d   = DONE;
         end
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= '0;
         acc_sr_q  <= '0;
         cnt_q     <= '0;
         acc_out_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_sr_q  <= acc_sr_d;
         cnt_q     <= cnt_d;
         acc_out_q <= acc_out_d;
         ovf_q     <= ovf_d;
      end
   assign bus.busy     = (state_q == SHIFT);
   assign bus.done     = (state_q == DONE);
   assign bus.acc_out  = acc_out_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_acc_datapath.sv
// tb_serial_acc_datapath: directed vectors with a done-driven scoreboard monitor
module tb_serial_acc_datapath;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   serial_acc_if #(.N(8)) bus();
   serial_acc_datapath #(.N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   typedef struct {
      logic [7:0] acc;
      logic       ovf;
      int         due;
   } exp_t;
   exp_t sb[$];
   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("acc_out", 32'(bus.acc_out), 32'(e.acc));
            chk("overflow", 32'(bus.overflow), 32'(e.ovf));
            chk("done_latency", cyc, e.due);
         end
      end
   end
   task automatic wait_done();
      for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clk);
      if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
   endtask
   task automatic do_load(input logic [7:0] v, input logic [7:0] exp_acc, input logic exp_ovf);
      @(negedge clk);
      bus.data_in = v;
      bus.load_input = 1'b1;
      sb.push_back('{exp_acc, exp_ovf, cyc + 9});
      @(negedge clk);
      bus.load_input = 1'b0;
      bus.data_in = ~v;
      wait_done();
   endtask
   task automatic pulse_clear();
      @(negedge clk);
      bus.clear_acc = 1'b1;
      @(negedge clk);
      bus.clear_acc = 1'b0;
   endtask
   task automatic chk_zero(input string name);
      chk({name, "_busy"}, 32'(bus.busy), 32'd0);
      chk({name, "_done"}, 32'(bus.done), 32'd0);
      chk({name, "_acc"}, 32'(bus.acc_out), 32'd0);
      chk({name, "_ovf"}, 32'(bus.overflow), 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.clear_acc = 1'b0;
      bus.load_input = 1'b0;
      bus.data_in = 8'h00;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;
      // reset mid-add, then clear held one cycle after release
      @(negedge clk);
      bus.data_in = 8'h40;
      bus.load_input = 1'b1;
      @(negedge clk);
      bus.load_input = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      bus.clear_acc = 1'b1;
      @(negedge clk);
      bus.clear_acc = 1'b0;
      chk_zero("post_reset");
      repeat (12) @(negedge clk);
      do_load(8'h05, 8'h05, 1'b0);
      do_load(8'h03, 8'h08, 1'b0);
      pulse_clear();
      do_load(8'hF0, 8'hF0, 1'b0);
      do_load(8'h20, 8'h10, 1'b1);
      do_load(8'h01, 8'h11, 1'b1);
      // abort an add after three shift edges
      pulse_clear();
      do_load(8'h0A, 8'h0A, 1'b0);
      @(negedge clk);
      bus.data_in = 8'h33;
      bus.load_input = 1'b1;
      @(negedge clk);
      bus.load_input = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_mid", 32'(bus.busy), 32'd1);
      bus.clear_acc = 1'b1;
      @(negedge clk);
      bus.clear_acc = 1'b0;
      chk_zero("abort");
      repeat (12) @(negedge clk);
      do_load(8'h07, 8'h07, 1'b0);
      // loads during SHIFT and DONE are ignored
      @(negedge clk);
      bus.data_in = 8'h11;
      bus.load_input = 1'b1;
      sb.push_back('{8'h18, 1'b0, cyc + 9});
      @(negedge clk);
      bus.load_input = 1'b0;
      repeat (2) @(negedge clk);
      bus.data_in = 8'hFF;
      bus.load_input = 1'b1;
      @(negedge clk);
      bus.load_input = 1'b0;
      wait_done();
      bus.load_input = 1'b1;
      @(negedge clk);
      bus.load_input = 1'b0;
      chk("ignored_load_busy", 32'(bus.busy), 32'd0);
      repeat (12) @(negedge clk);
      chk("ignored_load_acc", 32'(bus.acc_out), 32'h18);
      // simultaneous clear and load in IDLE
      @(negedge clk);
      bus.clear_acc = 1'b1;
      bus.load_input = 1'b1;
      bus.data_in = 8'h55;
      @(negedge clk);
      bus.clear_acc = 1'b0;
      bus.load_input = 1'b0;
      chk_zero("clear_load");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("clear_load_busy", 32'(bus.busy), 32'd0);
      end
      repeat (8) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
